// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: access widths, FSM states and
// big-endian byte-enable patterns used by the lane aligner.
package mem_stage_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Byte offset 0 is the most significant lane, so patterns shift right with offset.
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_NONE    = 4'b0000;

endpackage

// File: rtl/mem_stage_if.sv
// Single-port data-memory bus with a req/ack handshake; the stage is the
// master, the memory (or bench) is the slave.
interface mem_stage_if #(parameter int ADDR_W = 32);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              ack;
  logic [31:0]       rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);

endinterface

// File: rtl/mem_stage_lane_align.sv
// Combinational big-endian lane steering shared by the store path (byte
// enables, positioned write data) and the load path (lane select + extension).
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  input  logic        is_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];
  end

  // Store data is replicated into every lane; the byte enables pick the live one.
  always_comb begin
    be         = BE_NONE;
    wdata      = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    case (width)
      WIDTH_BYTE: begin
        be        = BE_BYTE0 >> offset;
        wdata     = {4{store_data[7:0]}};
        rdata_ext = is_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      WIDTH_HALF: begin
        misaligned = offset[0];
        be         = offset[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata      = {2{store_data[15:0]}};
        rdata_ext  = is_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      WIDTH_WORD: begin
        misaligned = (offset != 2'd0);
        be         = BE_WORD;
        wdata      = store_data;
        rdata_ext  = rdata;
      end
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through in one cycle, or runs a
// registered req/ack access and returns load data as a one-cycle write-back.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FLAGS_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic                   is_int_wb,
  input  logic                   is_mem,
  input  logic                   is_unsigned,
  input  logic [1:0]             data_width,
  input  logic [ADDR_W-1:0]      effective_address,
  input  logic [31:0]            value_to_be_store,
  input  logic [FLAGS_WIDTH-1:0] int_wb_address,
  input  logic [31:0]            int_wb_value,
  mem_stage_if.master            dmem,
  output logic                   stall,
  output logic                   wb_valid,
  output logic [FLAGS_WIDTH-1:0] wb_address,
  output logic [31:0]            wb_value,
  output logic                   addr_error
);

  state_e                 state_q, state_d;
  logic                   req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [3:0]             be_q, be_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [1:0]             width_q, width_d, offset_q, offset_d;
  logic                   unsigned_q, unsigned_d;
  logic                   wb_valid_q, wb_valid_d, addr_error_q, addr_error_d;
  logic [FLAGS_WIDTH-1:0] wb_address_q, wb_address_d;
  logic [31:0]            wb_value_q, wb_value_d;

  logic [1:0]  lane_width, lane_offset;
  logic        lane_unsigned, lane_misaligned;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  // Idle: steer the incoming instruction; access: steer the latched load attributes.
  assign lane_width    = (state_q == ACCESS) ? width_q    : data_width;
  assign lane_offset   = (state_q == ACCESS) ? offset_q   : effective_address[1:0];
  assign lane_unsigned = (state_q == ACCESS) ? unsigned_q : is_unsigned;

  mem_lane_align u_lane (
    .width      (lane_width),
    .offset     (lane_offset),
    .store_data (value_to_be_store),
    .rdata      (dmem.rdata),
    .is_unsigned(lane_unsigned),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .rdata_ext  (lane_rdata),
    .misaligned (lane_misaligned)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    we_d         = we_q;
    addr_d       = addr_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    width_d      = width_q;
    offset_d     = offset_q;
    unsigned_d   = unsigned_q;
    wb_valid_d   = 1'b0;
    wb_address_d = wb_address_q;
    wb_value_d   = wb_value_q;
    addr_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem) begin
            wb_valid_d   = is_int_wb;
            wb_address_d = int_wb_address;
            wb_value_d   = int_wb_value;
          end else if (lane_misaligned) begin
            addr_error_d = 1'b1;
          end else begin
            state_d      = ACCESS;
            req_d        = 1'b1;
            we_d         = !is_int_wb;
            addr_d       = {effective_address[ADDR_W-1:2], 2'b00};
            be_d         = lane_be;
            wdata_d      = lane_wdata;
            width_d      = data_width;
            offset_d     = effective_address[1:0];
            unsigned_d   = is_unsigned;
            wb_address_d = int_wb_address;
          end
        end
      end
      ACCESS: begin
        if (dmem.ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = !we_q;
          if (!we_q) wb_value_d = lane_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= '0;
      wdata_q      <= '0;
      width_q      <= '0;
      offset_q     <= '0;
      unsigned_q   <= 1'b0;
      wb_valid_q   <= 1'b0;
      wb_address_q <= '0;
      wb_value_q   <= '0;
      addr_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      be_q         <= be_d;
      wdata_q      <= wdata_d;
      width_q      <= width_d;
      offset_q     <= offset_d;
      unsigned_q   <= unsigned_d;
      wb_valid_q   <= wb_valid_d;
      wb_address_q <= wb_address_d;
      wb_value_q   <= wb_value_d;
      addr_error_q <= addr_error_d;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.be    = be_q;
  assign dmem.wdata = wdata_q;

  assign stall      = (state_q == ACCESS);
  assign wb_valid   = wb_valid_q;
  assign wb_address = wb_address_q;
  assign wb_value   = wb_value_q;
  assign addr_error = addr_error_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's per-instruction result (write-back request, memory request, effective address, width, store data).
- Performs byte/halfword/word loads and stores against a single-port data-memory interface with a req/ack handshake, or passes non-memory results straight through.
- Presents a registered write-back packet to the write-back stage and raises stall to upstream stages while a memory access is outstanding.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- FLAGS_WIDTH, 6, width of the write-back register address, matching the execute stage's int_wb_address.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute-stage output is a valid instruction this cycle.
- is_int_wb  in  1  instruction writes an integer register.
- is_mem  in  1  instruction accesses memory; is_mem=1 with is_int_wb=1 is a load, is_mem=1 with is_int_wb=0 is a store.
- is_unsigned  in  1  load zero-extends (lbu/lhu); ignored for stores and word loads.
- data_width  in  2  00 byte, 01 half, 10 word; 11 is reserved.
- effective_address  in  ADDR_W  byte address.
- value_to_be_store  in  32  store data, right-justified.
- int_wb_address  in  FLAGS_WIDTH  destination register.
- int_wb_value  in  32  ALU result for non-memory write-back.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  ADDR_W  word-aligned address, effective_address with bits [1:0] cleared.
- dmem_be  out  4  byte enables; bit3 = bits[31:24].
- dmem_wdata  out  32  lane-positioned store data.
- dmem_ack  in  1  access complete; dmem_rdata is valid in the same cycle.
- dmem_rdata  in  32  read word.
- stall  out  1  upstream must hold its outputs.
- wb_valid  out  1  write-back packet valid, one cycle per instruction.
- wb_address  out  FLAGS_WIDTH  destination register.
- wb_value  out  32  write-back data.
- addr_error  out  1  one-cycle pulse on a misaligned or reserved-width access.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE. Reset mid-access deasserts dmem_req on the next edge, and any late ack is ignored.
- Byte order is big-endian: byte offset 0 maps to lanes [31:24] (be=1000); offset 3 maps to [7:0] (be=0001). Half offset 0 maps to [31:16] (be=1100); half offset 2 maps to [15:0] (be=0011). Word uses be=1111.
- Alignment:
  - Half with addr[0]=1 is misaligned.
  - Word with addr[1:0]!=0 is misaligned.
  - data_width=11 is an error.
  - On any of these: addr_error pulses for 1 cycle, no memory request is issued, wb_valid stays 0, and the stage is ready next cycle.
- FSM IDLE:
  - in_valid && !is_mem: next cycle wb_valid = is_int_wb, wb_address/wb_value are registered. Latency is 1 and there is no stall.
  - in_valid && is_mem && aligned: go to ACCESS. On the same edge, register dmem_req=1, dmem_we=!is_int_wb, dmem_addr, dmem_be, dmem_wdata (store data replicated/shifted into its lane), latch wb_address, width, offset and is_unsigned. stall=1 from that cycle onward.
- FSM ACCESS:
  - Request signals are held stable until dmem_ack.
  - On ack: dmem_req drops at the edge. For a load, wb_valid=1 with wb_value = the selected lane, sign- or zero-extended to 32 bits. For a store, wb_valid=0. Go to IDLE; stall deasserts in the same cycle the result is registered.
- stall is combinational: (state==ACCESS).
- While stall=1, the stage ignores the in_* inputs; upstream holds them.
- Minimum load/store latency is 2 cycles (issue, ack on the next cycle). Ack arriving in the issue cycle is not possible because req is registered.
- wb_valid is a single-cycle pulse and is never asserted in two consecutive cycles for one instruction.
- dmem_ack while state==IDLE is ignored.

Decomposition:
- Shared package holds:
  - width encodings: WIDTH_BYTE=2'b00, WIDTH_HALF=2'b01, WIDTH_WORD=2'b10.
  - FSM state enum: IDLE, ACCESS.
  - Lane/byte-enable helper constants.
- One natural combinational sub-module, mem_lane_align: takes width, offset, store data, read data and is_unsigned; produces be, shifted wdata, extended rdata and misaligned. It is shared by the store and load paths.

Test Plan:
- ALU pass-through: in_valid=1, is_int_wb=1, is_mem=0, addr 5, value 0x1234 -> next cycle wb_valid=1, wb_address=5, wb_value=0x00001234, stall=0, dmem_req=0.
- Signed byte load: lb at 0x103, ack after 3 cycles with rdata=0x112233F0 -> stall=1 for those cycles, dmem_addr=0x100, dmem_be=0001, then wb_value=0xFFFFFFF0, wb_valid for exactly 1 cycle.
- Unsigned half load: lhu at 0x200, rdata=0x8001ABCD -> be=1100, wb_value=0x00008001.
- Byte store: sb at 0x301, data 0x000000A5 -> dmem_we=1, be=0100, wdata[23:16]=0xA5, addr 0x300; wb_valid stays 0; stall clears the cycle after ack.
- Misaligned word: lw at 0x402 -> addr_error pulses 1 cycle, no dmem_req, wb_valid=0; the next instruction is accepted immediately.
- Reset mid-access: lw issued, reset asserted before ack, then ack arrives -> dmem_req=0 and stall=0 after the reset edge; the late ack produces no wb_valid.
